// File: rtl/mcu_tx_arbiter_if.sv
// Bus bundle between the PIT lanes, the transmit arbiter and the NDN->MCU SPI slave.
// The grant_cnt member exists only when MCU_ARB_STATS_EN is defined.
interface mcu_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*64-1:0] req_prefix;
    logic [NUM_REQ*8-1:0]  req_byte;
    logic [NUM_REQ-1:0]    grant;
    logic [7:0]            rd_idx;
    logic [NUM_REQ-1:0]    done;
    logic                  busy;
    logic                  spi_start;
    logic [7:0]            spi_data;
    logic                  spi_valid;
    logic [63:0]           spi_prefix;
`ifdef MCU_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] grant_cnt;

    modport master (
        input  req, req_prefix, req_byte,
        output grant, rd_idx, done, busy, spi_start, spi_data, spi_valid, spi_prefix, grant_cnt
    );
    modport slave (
        output req, req_prefix, req_byte,
        input  grant, rd_idx, done, busy, spi_start, spi_data, spi_valid, spi_prefix, grant_cnt
    );
`else
    modport master (
        input  req, req_prefix, req_byte,
        output grant, rd_idx, done, busy, spi_start, spi_data, spi_valid, spi_prefix
    );
    modport slave (
        output req, req_prefix, req_byte,
        input  grant, rd_idx, done, busy, spi_start, spi_data, spi_valid, spi_prefix
    );
`endif
endinterface

// File: rtl/mcu_tx_arbiter.sv
// Round-robin owner of the MCU-facing SPI transmit path: grant, stream payload, hold through serialization.
// Optional per-lane grant statistics are enabled with the MCU_ARB_STATS_EN macro.
module mcu_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_BYTES = 32,
    parameter int SER_CYCLES = 321
) (
    input  logic             clk,
    input  logic             rst,
    mcu_tx_arbiter_if.master bus
);
    localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BCW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int DCW = (SER_CYCLES > 0) ? $clog2(SER_CYCLES + 1) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GRANT  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic               r_busy;
    logic               r_spi_start;
    logic               r_spi_valid;
    logic [7:0]         r_rd_idx;
    logic [63:0]        r_spi_prefix;
    logic [PW-1:0]      r_rr_ptr;
    logic [PW-1:0]      r_win;
    logic [BCW-1:0]     r_byte_cnt;
    logic [DCW-1:0]     r_drain_cnt;

    logic [PW-1:0]      w_sel_idx;
    logic               w_any_req;
    logic [PW:0]        w_cand;

    // Scan lanes starting at rr_ptr; the first requester found wins.
    always_comb begin
        w_sel_idx = r_rr_ptr;
        w_any_req = 1'b0;
        w_cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (PW+1)'(k);
            if (w_cand >= (PW+1)'(NUM_REQ)) begin
                w_cand = w_cand - (PW+1)'(NUM_REQ);
            end
            if (!w_any_req && bus.req[w_cand[PW-1:0]]) begin
                w_any_req = 1'b1;
                w_sel_idx = w_cand[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_done       <= '0;
            r_busy       <= 1'b0;
            r_spi_start  <= 1'b0;
            r_spi_valid  <= 1'b0;
            r_rd_idx     <= '0;
            r_spi_prefix <= '0;
            r_rr_ptr     <= '0;
            r_win        <= '0;
            r_byte_cnt   <= '0;
            r_drain_cnt  <= '0;
        end else begin
            r_spi_start <= 1'b0;
            r_done      <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state      <= S_GRANT;
                        r_win        <= w_sel_idx;
                        r_grant      <= NUM_REQ'(1) << w_sel_idx;
                        r_busy       <= 1'b1;
                        r_spi_start  <= 1'b1;
                        r_spi_prefix <= bus.req_prefix[w_sel_idx*64 +: 64];
                        r_rd_idx     <= '0;
                        r_byte_cnt   <= BCW'(DATA_BYTES - 1);
                    end
                end
                S_GRANT: begin
                    r_state     <= S_STREAM;
                    r_spi_valid <= 1'b1;
                end
                S_STREAM: begin
                    if (r_byte_cnt == '0) begin
                        r_state     <= S_DRAIN;
                        r_spi_valid <= 1'b0;
                        r_rd_idx    <= '0;
                        r_drain_cnt <= DCW'(SER_CYCLES - 1);
                    end else begin
                        r_byte_cnt <= r_byte_cnt - BCW'(1);
                        r_rd_idx   <= r_rd_idx + 8'd1;
                    end
                end
                S_DRAIN: begin
                    // The SPI slave is still shifting; keep the path owned until it finishes.
                    if (r_drain_cnt == '0) begin
                        r_state <= S_DONE;
                        r_done  <= r_grant;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DCW'(1);
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_grant  <= '0;
                    r_busy   <= 1'b0;
                    r_rr_ptr <= (r_win == PW'(NUM_REQ - 1)) ? '0 : r_win + PW'(1);
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant      = r_grant;
    assign bus.done       = r_done;
    assign bus.busy       = r_busy;
    assign bus.spi_start  = r_spi_start;
    assign bus.spi_valid  = r_spi_valid;
    assign bus.rd_idx     = r_rd_idx;
    assign bus.spi_prefix = r_spi_prefix;
    // The granted lane answers rd_idx combinationally, so the byte is forwarded without a register.
    assign bus.spi_data   = bus.req_byte[r_win*8 +: 8];

`ifdef MCU_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] r_grant_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_cnt <= '0;
        end else if (r_state == S_GRANT) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_grant[i] && (r_grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
                    r_grant_cnt[i*16 +: 16] <= r_grant_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end

    assign bus.grant_cnt = r_grant_cnt;
`endif
endmodule

// File: tb/tb_mcu_tx_arbiter.sv
// Scoreboard bench for mcu_tx_arbiter: directed stimulus queues timed expectations, a monitor pops them.
// Statistics checks are compiled in when MCU_ARB_STATS_EN is defined.
module tb_mcu_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam logic [7:0]  LANE_XOR [4] = '{8'h80, 8'h00, 8'h40, 8'hC0};
    localparam logic [63:0] PREFIX   [4] = '{64'h0000_1111_0000_0A00, 64'hA5A5_0000_1234_5678,
                                             64'hC3C3_2222_0000_0002, 64'h3C3C_3333_FFFF_0003};

    typedef struct {
        int          kind;
        int          cyc;
        logic [63:0] val;
        logic [3:0]  lanes;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    exp_t  q[$];
    string kname [3] = '{"start", "byte", "done"};

    mcu_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    mcu_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_BYTES(32), .SER_CYCLES(321)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Lane model: each lane returns payload[rd_idx] = rd_idx ^ lane tag.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_byte[i*8 +: 8] = bus.rd_idx ^ LANE_XOR[i];
        end
    end

    function automatic void push(input int kind, input int c, input logic [63:0] val, input logic [3:0] lanes);
        exp_t e;
        e.kind  = kind;
        e.cyc   = c;
        e.val   = val;
        e.lanes = lanes;
        q.push_back(e);
    endfunction

    // Expected events for a lane whose request is first seen in IDLE at cycle t.
    function automatic void push_packet(input int lane, input int t, input int nbytes, input bit with_done);
        logic [3:0] oh;
        oh = 4'(1 << lane);
        push(0, t + 1, PREFIX[lane], oh);
        for (int k = 0; k < nbytes; k++) begin
            push(1, t + 2 + k, {56'h0, LANE_XOR[lane] ^ 8'(k)}, oh);
        end
        if (with_done) push(2, t + 355, {52'h0, 8'h00, oh}, oh);
    endfunction

    task automatic sb_check(input int kind, input logic [63:0] val, input logic [3:0] lanes);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_%s cyc=%0d got val=%h lanes=%b required no event", kname[kind], cyc, val, lanes);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val != val || e.lanes != lanes) begin
                failures++;
                $display("FAIL sb_%s got kind=%s cyc=%0d val=%h lanes=%b required kind=%s cyc=%0d val=%h lanes=%b",
                         kname[e.kind], kname[kind], cyc, val, lanes, kname[e.kind], e.cyc, e.val, e.lanes);
            end
        end
    endtask

    always @(negedge clk) begin
        checks++;
        if (!$onehot0(bus.grant) || !$onehot0(bus.done) || (bus.spi_start && bus.done != '0)
            || (bus.busy != (bus.grant != '0))) begin
            failures++;
            $display("FAIL invariant cyc=%0d got grant=%b done=%b start=%b busy=%b required onehot0 grant/done, no start with done, busy==|grant",
                     cyc, bus.grant, bus.done, bus.spi_start, bus.busy);
        end
        if (bus.spi_start)   sb_check(0, bus.spi_prefix, bus.grant);
        if (bus.spi_valid)   sb_check(1, {56'h0, bus.spi_data}, bus.grant);
        if (bus.done != '0)  sb_check(2, {52'h0, bus.rd_idx, bus.grant}, bus.done);
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (bus.grant !== '0 || bus.done !== '0 || bus.busy !== 1'b0 || bus.spi_start !== 1'b0
            || bus.spi_valid !== 1'b0 || bus.rd_idx !== 8'h00 || bus.spi_prefix !== 64'h0) begin
            failures++;
            $display("FAIL %s got grant=%b done=%b busy=%b start=%b valid=%b rd_idx=%h prefix=%h required all zero",
                     name, bus.grant, bus.done, bus.busy, bus.spi_start, bus.spi_valid, bus.rd_idx, bus.spi_prefix);
        end
    endtask

    // Called at a falling edge; reset is applied away from both edges and held over one rising edge.
    task automatic pulse_reset(input string name);
        #2;
        rst     = 1'b1;
        bus.req = '0;
        @(negedge clk);
        check_zero(name);
        #2;
        rst = 1'b0;
    endtask

    // One lane requests alone; optionally drops its request early, otherwise at done.
    task automatic single(input int lane, input int drop_at);
        int t;
        t = cyc;
        bus.req = 4'(1 << lane);
        push_packet(lane, t, 32, 1'b1);
        if (drop_at > 0) begin
            wait_until(t + drop_at);
            bus.req = '0;
        end
        wait_until(t + 355);
        bus.req = '0;
        wait_until(t + 356);
    endtask

    initial begin
        int t;
        bus.req        = '0;
        bus.req_prefix = {PREFIX[3], PREFIX[2], PREFIX[1], PREFIX[0]};
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);

        // Reset during lane 2 streaming: ten bytes go out, then nothing and no done.
        t = cyc;
        bus.req = 4'b0100;
        push_packet(2, t, 10, 1'b0);
        wait_until(t + 11);
        pulse_reset("reset_mid_stream");
        @(negedge clk);
        single(2, 0);

        // Single packet from lane 1 with the reference prefix and payload 0x00..0x1F.
        single(1, 0);

        // Round robin from a fresh pointer: 0,1,2,3,0 exactly 356 cycles apart.
        pulse_reset("reset_before_rr");
        @(negedge clk);
        t = cyc;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) push_packet(k % 4, t + 356 * k, 32, 1'b1);
        wait_until(t + 356 * 4 + 1);
        bus.req = '0;
        wait_until(t + 356 * 5);

        // Late arrival: lane 1 asks during lane 3's drain and wins the next IDLE.
        t = cyc;
        bus.req = 4'b1000;
        push_packet(3, t, 32, 1'b1);
        wait_until(t + 200);
        bus.req = 4'b1010;
        push_packet(1, t + 356, 32, 1'b1);
        wait_until(t + 355);
        bus.req = 4'b0010;
        wait_until(t + 356 + 355);
        bus.req = '0;
        wait_until(t + 712);

        // Lane 0 drops its request mid-stream; the packet still completes.
        single(0, 10);

`ifdef MCU_ARB_STATS_EN
        pulse_reset("reset_before_stats");
        @(negedge clk);
        for (int k = 0; k < 3; k++) single(1, 0);
        checks++;
        if (bus.grant_cnt !== 64'h0000_0000_0003_0000) begin
            failures++;
            $display("FAIL grant_cnt_three got %h required %h", bus.grant_cnt, 64'h0000_0000_0003_0000);
        end
        force dut.r_grant_cnt = 64'h0000_0000_FFFF_0000;
        @(negedge clk);
        release dut.r_grant_cnt;
        single(1, 0);
        checks++;
        if (bus.grant_cnt !== 64'h0000_0000_FFFF_0000) begin
            failures++;
            $display("FAIL grant_cnt_saturate got %h required %h", bus.grant_cnt, 64'h0000_0000_FFFF_0000);
        end
`endif

        repeat (5) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got %0d pending events required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got cyc=%0d required completion before time limit", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
